// File: rtl/mem_access_unit_if.sv
// Data-memory port between the MEM-stage sequencer (master) and data memory (slave).
// Handshake: a request is held stable until the memory answers with mem_resp.
interface mem_access_unit_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer for the pipelined LC-3b core: runs LDR/STR/LDB/STB/LDI/STI
// as one or two memory transactions, stalls the pipeline meanwhile, and formats load data.
module mem_access_unit (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      xm_valid,
  input  logic                      xm_read,
  input  logic                      xm_write,
  input  logic                      xm_indirect,
  input  logic                      xm_byte,
  input  logic [15:0]               xm_addr,
  input  logic [15:0]               xm_wdata,
  mem_access_unit_if.master         mem,
  output logic                      mem_stall,
  output logic                      done,
  output logic [15:0]               rdata
);

  typedef enum logic [1:0] {IDLE, PTR, RD, WR} state_t;

  state_t      state, state_next;
  logic [15:0] ptr_reg;
  logic        mem_op;
  logic        byte_direct;
  logic [15:0] addr_word;
  logic [15:0] data_addr;

  // A simultaneous read and write request is illegal and resolves as a read.
  assign mem_op      = xm_valid & (xm_read | xm_write);
  // Indirect ops ignore the byte flag: the pointed-to access is always a word.
  assign byte_direct = xm_byte & ~xm_indirect;
  assign addr_word   = {xm_addr[15:1], 1'b0};
  assign data_addr   = xm_indirect ? {ptr_reg[15:1], 1'b0}
                     : (xm_byte ? xm_addr : addr_word);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr_reg <= '0;
    end else begin
      state <= state_next;
      if (state == PTR && mem.mem_resp)
        ptr_reg <= mem.mem_rdata;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next          = state;
    mem.mem_read        = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_address     = '0;
    mem.mem_wdata       = '0;
    mem.mem_byte_enable = 2'b11;
    mem_stall           = 1'b0;
    done                = 1'b0;
    rdata               = '0;

    case (state)
      IDLE: begin
        // Any mem_resp here is stale or stray and is deliberately ignored.
        if (mem_op) begin
          mem_stall = 1'b1;
          if (xm_indirect)  state_next = PTR;
          else if (xm_read) state_next = RD;
          else              state_next = WR;
        end
      end

      PTR: begin
        mem.mem_read    = 1'b1;
        mem.mem_address = addr_word;
        mem_stall       = 1'b1;
        if (mem.mem_resp)
          state_next = xm_read ? RD : WR;
      end

      RD: begin
        mem.mem_read    = 1'b1;
        mem.mem_address = data_addr;
        if (mem.mem_resp) begin
          // Stall drops in the final response cycle so X/M advances on this edge.
          done       = 1'b1;
          state_next = IDLE;
          if (byte_direct)
            rdata = xm_addr[0] ? {8'h00, mem.mem_rdata[15:8]}
                               : {8'h00, mem.mem_rdata[7:0]};
          else
            rdata = mem.mem_rdata;
        end else begin
          mem_stall = 1'b1;
        end
      end

      WR: begin
        mem.mem_write   = 1'b1;
        mem.mem_address = data_addr;
        if (byte_direct) begin
          mem.mem_wdata       = {xm_wdata[7:0], xm_wdata[7:0]};
          mem.mem_byte_enable = xm_addr[0] ? 2'b10 : 2'b01;
        end else begin
          mem.mem_wdata = xm_wdata;
        end
        if (mem.mem_resp) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized memory ops
// checked cycle by cycle against a transaction-level model of the access sequence.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        xm_valid, xm_read, xm_write, xm_indirect, xm_byte;
  logic [15:0] xm_addr, xm_wdata;
  logic        mem_stall, done;
  logic [15:0] rdata;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .xm_valid   (xm_valid),
    .xm_read    (xm_read),
    .xm_write   (xm_write),
    .xm_indirect(xm_indirect),
    .xm_byte    (xm_byte),
    .xm_addr    (xm_addr),
    .xm_wdata   (xm_wdata),
    .mem        (bus),
    .mem_stall  (mem_stall),
    .done       (done),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs expected whenever no request is in flight.
  task automatic check_quiet(input string tag, input bit exp_stall);
    @(negedge clk);
    check({tag, ".read"},  bus.mem_read, 0);
    check({tag, ".write"}, bus.mem_write, 0);
    check({tag, ".addr"},  bus.mem_address, 0);
    check({tag, ".wdata"}, bus.mem_wdata, 0);
    check({tag, ".be"},    bus.mem_byte_enable, 2'b11);
    check({tag, ".stall"}, mem_stall, exp_stall);
    check({tag, ".done"},  done, 0);
    check({tag, ".rdata"}, rdata, 0);
  endtask

  // Issues one memory instruction and plays the memory side. Called just after a
  // rising edge with the DUT idle; returns just after the edge that ends the op.
  task automatic run_op(input string tag, input bit rd, input bit wr, input bit ind,
                        input bit byt, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] ptr_val, input logic [15:0] rd_val,
                        input int k1, input int k2);
    bit          is_read;
    int          n;
    int          idx;
    bit          acc_wr  [2];
    logic [15:0] acc_addr[2];
    logic [15:0] acc_wd  [2];
    logic [1:0]  acc_be  [2];
    logic [15:0] acc_resp[2];
    int          acc_k   [2];
    logic [15:0] exp_rdata;
    bit          last, fin;

    is_read = rd;
    n       = ind ? 2 : 1;
    idx     = ind ? 1 : 0;
    if (ind) begin
      acc_wr[0] = 1'b0; acc_addr[0] = addr & 16'hFFFE; acc_wd[0] = 16'h0;
      acc_be[0] = 2'b11; acc_resp[0] = ptr_val; acc_k[0] = k1;
      acc_addr[1] = ptr_val & 16'hFFFE;
      acc_k[1]    = k2;
    end else begin
      acc_addr[0] = byt ? addr : (addr & 16'hFFFE);
      acc_k[0]    = k1;
    end
    acc_wr[idx]   = !is_read;
    acc_resp[idx] = rd_val;
    if (is_read) begin
      acc_wd[idx] = 16'h0; acc_be[idx] = 2'b11;
    end else if (byt && !ind) begin
      acc_wd[idx] = {wdata[7:0], wdata[7:0]};
      acc_be[idx] = addr[0] ? 2'b10 : 2'b01;
    end else begin
      acc_wd[idx] = wdata; acc_be[idx] = 2'b11;
    end
    if (!is_read)             exp_rdata = 16'h0;
    else if (byt && !ind)     exp_rdata = addr[0] ? {8'h00, rd_val[15:8]} : {8'h00, rd_val[7:0]};
    else                      exp_rdata = rd_val;

    xm_valid = 1'b1; xm_read = rd; xm_write = wr; xm_indirect = ind; xm_byte = byt;
    xm_addr = addr; xm_wdata = wdata;
    bus.mem_resp = 1'b0; bus.mem_rdata = 16'($urandom);
    check_quiet({tag, ".c0"}, 1'b1);

    for (int a = 0; a < n; a++) begin
      for (int w = 0; w <= acc_k[a]; w++) begin
        step();
        last = (w == acc_k[a]);
        fin  = last && (a == n - 1);
        bus.mem_resp  = last;
        bus.mem_rdata = last ? acc_resp[a] : 16'($urandom);
        @(negedge clk);
        check({tag, ".read"},  bus.mem_read, !acc_wr[a]);
        check({tag, ".write"}, bus.mem_write, acc_wr[a]);
        check({tag, ".addr"},  bus.mem_address, acc_addr[a]);
        check({tag, ".wdata"}, bus.mem_wdata, acc_wd[a]);
        check({tag, ".be"},    bus.mem_byte_enable, acc_be[a]);
        check({tag, ".stall"}, mem_stall, !fin);
        check({tag, ".done"},  done, fin);
        check({tag, ".rdata"}, rdata, fin ? exp_rdata : 16'h0);
      end
    end
    step();
    bus.mem_resp = 1'b0;
    xm_valid     = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    xm_valid = 0; xm_read = 0; xm_write = 0; xm_indirect = 0; xm_byte = 0;
    xm_addr = 0; xm_wdata = 0;
    bus.mem_resp = 0; bus.mem_rdata = 0;
    step();
    step();
    check_quiet("reset", 1'b0);
    step();
    reset = 1'b0;

    // Non-memory instruction with a stray response: no stall, no request, no done.
    xm_valid = 1'b1; xm_read = 0; xm_write = 0; bus.mem_resp = 1'b1;
    check_quiet("nonmem", 1'b0);
    step();
    xm_valid = 1'b0; bus.mem_resp = 1'b0;

    run_op("ldr",    1, 0, 0, 0, 16'h1002, 16'h0000, 16'h0000, 16'hBEEF, 2, 0);
    run_op("ldb_hi", 1, 0, 0, 1, 16'h2001, 16'h0000, 16'h0000, 16'hA55A, 1, 0);
    run_op("ldb_lo", 1, 0, 0, 1, 16'h2000, 16'h0000, 16'h0000, 16'hA55A, 0, 0);
    run_op("stb",    0, 1, 0, 1, 16'h3003, 16'h12C4, 16'h0000, 16'h7777, 1, 0);
    run_op("str",    0, 1, 0, 0, 16'h3003, 16'h12C4, 16'h0000, 16'h7777, 0, 0);
    run_op("ldi",    1, 0, 1, 0, 16'h4000, 16'h0000, 16'h5007, 16'h0F0F, 1, 2);
    run_op("sti",    0, 1, 1, 0, 16'h4000, 16'h1234, 16'h6000, 16'h0000, 0, 1);
    run_op("stib",   0, 1, 1, 1, 16'h4001, 16'hABCD, 16'h6001, 16'h0000, 0, 0);
    run_op("illegal",1, 1, 0, 0, 16'h5555, 16'h9999, 16'h0000, 16'h4321, 0, 0);

    // Abort an outstanding read with reset, then send a stale response.
    xm_valid = 1'b1; xm_read = 1'b1; xm_write = 1'b0; xm_indirect = 1'b0; xm_byte = 1'b0;
    xm_addr = 16'h1002;
    step();
    @(negedge clk);
    check("abort.in_rd", bus.mem_read, 1);
    step();
    reset = 1'b1; xm_valid = 1'b0;
    step();
    reset = 1'b0; bus.mem_resp = 1'b1; bus.mem_rdata = 16'hFFFF;
    check_quiet("abort.stale", 1'b0);
    step();
    bus.mem_resp = 1'b0;
    check_quiet("abort.idle", 1'b0);
    step();
    run_op("after_rst", 1, 0, 0, 0, 16'h1002, 16'h0000, 16'h0000, 16'h2468, 0, 0);

    for (int i = 0; i < 150; i++) begin
      bit r, w;
      r = 1'($urandom_range(0, 1));
      w = r ? (($urandom_range(0, 7)) == 0) : 1'b1;
      run_op("rand", r, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        bus.mem_resp = 1'($urandom_range(0, 1));
        check_quiet("rand_gap", 1'b0);
        step();
        bus.mem_resp = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
